// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multi-cycle MIPS core (16-bit encoding) with req/ack memory ports
module mips_multicycle_core #(
   parameter int DATA_W  = 16,
   parameter int PC_W    = 16,
   parameter int PC_STEP = 2
) (
   input  logic              clock,
   input  logic              reset,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [15:0]       imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [PC_W-1:0]   dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [15:0]       ir,
   output logic              wb_valid,
   output logic [1:0]        wb_reg,
   output logic [DATA_W-1:0] wb_data,
   output logic              halted
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_ADDI = 4'b0100;
   localparam logic [3:0] OP_LW   = 4'b0101;
   localparam logic [3:0] OP_SW   = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_BEQ  = 4'b1000;
   localparam logic [3:0] OP_HALT = 4'b1111;

   // Branch offsets are in instructions; scale to bytes with a shift.
   localparam int STEP_SH = (PC_STEP == 4) ? 2 : ((PC_STEP == 2) ? 1 : 0);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d;
   logic [DATA_W-1:0] rf_q [4];
   logic [DATA_W-1:0] rf_d [4];
   logic              imem_req_q, imem_req_d;
   logic              dmem_req_q, dmem_req_d;
   logic              dmem_we_q, dmem_we_d;
   logic [PC_W-1:0]   dmem_addr_q, dmem_addr_d;
   logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
   logic              wb_valid_q, wb_valid_d;
   logic [1:0]        wb_reg_q, wb_reg_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              halted_q, halted_d;

   logic [3:0]        op;
   logic [1:0]        rs, rt, rd, alu_dest;
   logic [DATA_W-1:0] imm_ext, alu_res;
   logic [PC_W-1:0]   br_off, addr_calc;
   logic              is_rtype;

   assign op       = ir_q[15:12];
   assign rs       = ir_q[11:10];
   assign rt       = ir_q[9:8];
   assign rd       = ir_q[7:6];
   assign imm_ext  = DATA_W'($signed(ir_q[7:0]));
   assign br_off   = PC_W'($signed(ir_q[7:0])) << STEP_SH;
   assign is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                     (op == OP_OR)  || (op == OP_SLT);
   assign alu_dest = is_rtype ? rd : rt;

   // Effective address is the low PC_W bits of the ALU result, zero-extended when narrower.
   if (PC_W <= DATA_W) begin : g_addr_trunc
      assign addr_calc = alu_res[PC_W-1:0];
   end else begin : g_addr_ext
      assign addr_calc = {{(PC_W-DATA_W){1'b0}}, alu_res};
   end

   // ALU operating on the operand latches captured in DECODE.
   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:                alu_res = a_q + b_q;
         OP_SUB:                alu_res = a_q - b_q;
         OP_AND:                alu_res = a_q & b_q;
         OP_OR:                 alu_res = a_q | b_q;
         OP_SLT:                alu_res = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
         OP_ADDI, OP_LW, OP_SW: alu_res = a_q + imm_ext;
         default:               alu_res = '0;
      endcase
   end

   // Next-state and next-output logic for the FETCH/DECODE/EXEC/MEM/WB/HALT sequencer.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      a_d          = a_q;
      b_d          = b_q;
      alu_d        = alu_q;
      imem_req_d   = imem_req_q;
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      wb_valid_d   = 1'b0;
      wb_reg_d     = wb_reg_q;
      wb_data_d    = wb_data_q;
      halted_d     = halted_q;
      rf_d         = rf_q;
      // The write lands at the edge closing the WB cycle, while wb_valid is high.
      if (wb_valid_q) rf_d[wb_reg_q] = wb_data_q;
      rf_d[0] = '0;

      case (state_q)
         S_FETCH: begin
            if (!imem_req_q) begin
               // Only after reset: raise the request one cycle later.
               imem_req_d = 1'b1;
            end else if (imem_ack) begin
               ir_d       = imem_rdata;
               pc_d       = pc_q + PC_W'(PC_STEP);
               imem_req_d = 1'b0;
               state_d    = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d = (rs == 2'd0) ? '0 : rf_q[rs];
            b_d = (rt == 2'd0) ? '0 : rf_q[rt];
            if (op == OP_HALT) begin
               halted_d = 1'b1;
               state_d  = S_HALT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_d = alu_res;
            if (op == OP_BEQ) begin
               if (a_q == b_q) pc_d = pc_q + br_off;
               imem_req_d = 1'b1;
               state_d    = S_FETCH;
            end else if (op == OP_LW || op == OP_SW) begin
               dmem_req_d   = 1'b1;
               dmem_we_d    = (op == OP_SW);
               dmem_addr_d  = addr_calc;
               dmem_wdata_d = b_q;
               state_d      = S_MEM;
            end else if (is_rtype || op == OP_ADDI) begin
               wb_valid_d = (alu_dest != 2'd0);
               wb_reg_d   = alu_dest;
               wb_data_d  = alu_res;
               state_d    = S_WB;
            end else begin
               imem_req_d = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_MEM: begin
            if (dmem_ack) begin
               dmem_req_d = 1'b0;
               if (dmem_we_q) begin
                  imem_req_d = 1'b1;
                  state_d    = S_FETCH;
               end else begin
                  wb_valid_d = (rt != 2'd0);
                  wb_reg_d   = rt;
                  wb_data_d  = dmem_rdata;
                  state_d    = S_WB;
               end
            end
         end
         S_WB: begin
            imem_req_d = 1'b1;
            state_d    = S_FETCH;
         end
         default: begin
            state_d = S_HALT;
         end
      endcase
   end

   // All architectural and output state, asynchronously cleared.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_FETCH;
         pc_q         <= '0;
         ir_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         alu_q        <= '0;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         wb_valid_q   <= 1'b0;
         wb_reg_q     <= '0;
         wb_data_q    <= '0;
         halted_q     <= 1'b0;
         for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         a_q          <= a_d;
         b_q          <= b_d;
         alu_q        <= alu_d;
         imem_req_q   <= imem_req_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         wb_valid_q   <= wb_valid_d;
         wb_reg_q     <= wb_reg_d;
         wb_data_q    <= wb_data_d;
         halted_q     <= halted_d;
         for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = pc_q;
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;
   assign ir         = ir_q;
   assign wb_valid   = wb_valid_q;
   assign wb_reg     = wb_reg_q;
   assign wb_data    = wb_data_q;
   assign halted     = halted_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - scoreboard bench for mips_multicycle_core
module tb_mips_multicycle_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, rst32;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   last_wb  = 0;
   int   last_wb_w = 0;

   // 16-bit core and its memories
   logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, wb_valid, halted;
   logic [15:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, ir, wb_data;
   logic [1:0]  wb_reg;
   logic [15:0] imem [64];
   logic [15:0] dmem [64];
   int          imem_wait, dmem_wait, icnt, dcnt;

   assign imem_ack   = imem_req && (icnt >= imem_wait);
   assign imem_rdata = imem[imem_addr[6:1]];
   assign dmem_ack   = dmem_req && (dcnt >= dmem_wait);
   assign dmem_rdata = dmem[dmem_addr[6:1]];

   mips_multicycle_core #(.DATA_W(16), .PC_W(16), .PC_STEP(2)) dut (
      .clock(clk), .reset(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .ir(ir),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .halted(halted)
   );

   // 32-bit core, zero-wait memories
   logic        imem_req_w, imem_ack_w, dmem_req_w, dmem_we_w, dmem_ack_w, wb_valid_w, halted_w;
   logic [15:0] imem_addr_w, imem_rdata_w, dmem_addr_w, ir_w;
   logic [31:0] dmem_wdata_w, dmem_rdata_w, wb_data_w;
   logic [1:0]  wb_reg_w;
   logic [15:0] imem32 [8];

   assign imem_ack_w   = imem_req_w;
   assign imem_rdata_w = imem32[imem_addr_w[3:1]];
   assign dmem_ack_w   = dmem_req_w;
   assign dmem_rdata_w = 32'h0;

   mips_multicycle_core #(.DATA_W(32), .PC_W(16), .PC_STEP(2)) dut32 (
      .clock(clk), .reset(rst32),
      .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
      .dmem_req(dmem_req_w), .dmem_we(dmem_we_w), .dmem_addr(dmem_addr_w), .dmem_wdata(dmem_wdata_w),
      .dmem_ack(dmem_ack_w), .dmem_rdata(dmem_rdata_w), .ir(ir_w),
      .wb_valid(wb_valid_w), .wb_reg(wb_reg_w), .wb_data(wb_data_w), .halted(halted_w)
   );

   typedef struct { logic [1:0] r; logic [31:0] d; int gap; } wb_t;
   typedef struct { logic we; logic [15:0] addr; logic [15:0] wd; } dm_t;
   wb_t wbq[$];
   wb_t wbq_w[$];
   dm_t dq[$];
   int  fq[$];
   wb_t we_cur;
   wb_t we_cur_w;
   dm_t de_cur;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_wb(input logic [1:0] r, input logic [31:0] d, input int gap);
      wb_t e;
      e.r = r; e.d = d; e.gap = gap;
      wbq.push_back(e);
   endtask

   task automatic begin_test();
      @(negedge clk);
      rst = 1'b1;
      wbq.delete(); fq.delete(); dq.delete();
      for (int i = 0; i < 64; i++) imem[i] = 16'hF000;
      @(negedge clk);
   endtask

   task automatic run_until_halt(input string tag, input int bound);
      for (int i = 0; i < bound && !halted; i++) @(negedge clk);
      check_eq(tag, 32'(halted), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic end_test(input string tag);
      check_eq({tag, "_wb_left"}, 32'(wbq.size()), 32'd0);
      check_eq({tag, "_dmem_left"}, 32'(dq.size()), 32'd0);
      check_eq({tag, "_fetch_left"}, 32'(fq.size()), 32'd0);
   endtask

   // Cycle counter and wait-state counters for the ack models.
   always @(posedge clk) begin
      cyc  <= cyc + 1;
      icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
      dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
   end

   // Write-back scoreboard for the 16-bit core.
   always @(negedge clk) begin
      if (wb_valid) begin
         if (wbq.size() == 0) begin
            check_eq("wb_unexpected", 32'(wb_valid), 32'd0);
         end else begin
            we_cur = wbq.pop_front();
            check_eq("wb_reg", 32'(wb_reg), 32'(we_cur.r));
            check_eq("wb_data", 32'(wb_data), we_cur.d);
            if (we_cur.gap >= 0) check_eq("wb_gap", 32'(cyc - last_wb), 32'(we_cur.gap));
         end
         last_wb = cyc;
      end
   end

   // Fetch-address scoreboard (only when a test queued expectations).
   always @(negedge clk) begin
      if (imem_req && imem_ack && fq.size() != 0)
         check_eq("fetch_addr", 32'(imem_addr), 32'(fq.pop_front()));
   end

   // Data-port scoreboard: request fields must hold for every wait cycle; store on ack.
   always @(negedge clk) begin
      if (dmem_req) begin
         if (dq.size() == 0) begin
            check_eq("dmem_unexpected", 32'(dmem_req), 32'd0);
         end else begin
            de_cur = dq[0];
            check_eq("dmem_we", 32'(dmem_we), 32'(de_cur.we));
            check_eq("dmem_addr", 32'(dmem_addr), 32'(de_cur.addr));
            if (de_cur.we) check_eq("dmem_wdata", 32'(dmem_wdata), 32'(de_cur.wd));
            if (dmem_ack) begin
               if (dmem_we) dmem[dmem_addr[6:1]] = dmem_wdata;
               de_cur = dq.pop_front();
            end
         end
      end
   end

   // Write-back scoreboard for the 32-bit core.
   always @(negedge clk) begin
      if (wb_valid_w) begin
         if (wbq_w.size() == 0) begin
            check_eq("wb32_unexpected", 32'(wb_valid_w), 32'd0);
         end else begin
            we_cur_w = wbq_w.pop_front();
            check_eq("wb32_reg", 32'(wb_reg_w), 32'(we_cur_w.r));
            check_eq("wb32_data", wb_data_w, we_cur_w.d);
            if (we_cur_w.gap >= 0) check_eq("wb32_gap", 32'(cyc - last_wb_w), 32'(we_cur_w.gap));
         end
         last_wb_w = cyc;
      end
   end

   initial begin
      rst = 1'b1; rst32 = 1'b1;
      imem_wait = 0; dmem_wait = 0;
      for (int i = 0; i < 64; i++) begin imem[i] = 16'hF000; dmem[i] = 16'h0; end
      for (int i = 0; i < 8; i++) imem32[i] = 16'hF000;
      imem32[0] = 16'h41FF;   // addi $1,$0,-1
      imem32[1] = 16'h7480;   // slt  $2,$1,$0

      // Reset values
      @(negedge clk);
      check_eq("rst_imem_req", 32'(imem_req), 32'd0);
      check_eq("rst_imem_addr", 32'(imem_addr), 32'd0);
      check_eq("rst_dmem_req", 32'(dmem_req), 32'd0);
      check_eq("rst_dmem_we", 32'(dmem_we), 32'd0);
      check_eq("rst_dmem_addr", 32'(dmem_addr), 32'd0);
      check_eq("rst_dmem_wdata", 32'(dmem_wdata), 32'd0);
      check_eq("rst_ir", 32'(ir), 32'd0);
      check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
      check_eq("rst_wb_data", 32'(wb_data), 32'd0);
      check_eq("rst_halted", 32'(halted), 32'd0);

      // ALU program, zero-wait memories
      begin_test();
      imem[0] = 16'h410F; imem[1] = 16'h4207; imem[2] = 16'h26C0; imem[3] = 16'h1780;
      imem[4] = 16'h3B80; imem[5] = 16'h0BC0; imem[6] = 16'h7E40; imem[7] = 16'h7B40;
      push_wb(2'd1, 32'd15, -1); push_wb(2'd2, 32'd7, 4);  push_wb(2'd3, 32'd7, 4);
      push_wb(2'd2, 32'd8, 4);   push_wb(2'd2, 32'd15, 4); push_wb(2'd3, 32'd22, 4);
      push_wb(2'd1, 32'd0, 4);   push_wb(2'd1, 32'd1, 4);
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("first_req_after_rst", 32'(imem_req), 32'd1);
      check_eq("first_fetch_addr", 32'(imem_addr), 32'd0);
      run_until_halt("alu_halt", 300);
      end_test("alu");

      // sw then lw through a 3-wait data port
      begin_test();
      dmem_wait = 3;
      imem[0] = 16'h415A; imem[1] = 16'h6110; imem[2] = 16'h5210;
      push_wb(2'd1, 32'h5A, -1); push_wb(2'd2, 32'h5A, 15);
      dq.push_back('{1'b1, 16'h0010, 16'h005A});
      dq.push_back('{1'b0, 16'h0010, 16'h0000});
      rst = 1'b0;
      run_until_halt("mem_halt", 300);
      end_test("mem");
      dmem_wait = 0;

      // beq taken: self-loop at PC 6
      begin_test();
      imem[0] = 16'h4103; imem[1] = 16'h4204; imem[2] = 16'hA000; imem[3] = 16'h85FF;
      push_wb(2'd1, 32'd3, -1); push_wb(2'd2, 32'd4, 4);
      fq.push_back(0); fq.push_back(2); fq.push_back(4);
      for (int i = 0; i < 6; i++) fq.push_back(6);
      rst = 1'b0;
      for (int i = 0; i < 200 && fq.size() != 0; i++) @(negedge clk);
      check_eq("beq_loop_fetches", 32'(fq.size()), 32'd0);
      check_eq("beq_loop_not_halted", 32'(halted), 32'd0);
      end_test("beq_t");

      // beq not taken: falls through to PC 8
      begin_test();
      imem[0] = 16'h4103; imem[1] = 16'h4204; imem[2] = 16'hA000; imem[3] = 16'h86FF;
      push_wb(2'd1, 32'd3, -1); push_wb(2'd2, 32'd4, 4);
      fq.push_back(0); fq.push_back(2); fq.push_back(4); fq.push_back(6); fq.push_back(8);
      rst = 1'b0;
      run_until_halt("beq_nt_halt", 300);
      end_test("beq_nt");

      // $0 write, unknown opcode, halt
      begin_test();
      imem[0] = 16'h4005; imem[1] = 16'hA000; imem[2] = 16'hF000;
      fq.push_back(0); fq.push_back(2); fq.push_back(4);
      rst = 1'b0;
      run_until_halt("nop_halt", 300);
      check_eq("halt_pc", 32'(imem_addr), 32'd6);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_eq("halt_held", 32'(halted), 32'd1);
         check_eq("halt_no_req", 32'(imem_req), 32'd0);
      end
      end_test("nop");

      // Reset during a fetch wait
      begin_test();
      imem_wait = 5;
      imem[0] = 16'h4109; imem[1] = 16'h4109;
      push_wb(2'd1, 32'd9, -1);
      rst = 1'b0;
      for (int i = 0; i < 100 && !wb_valid; i++) @(negedge clk);
      check_eq("rstmid_first_wb", 32'(wb_valid), 32'd1);
      repeat (2) @(negedge clk);
      check_eq("rstmid_req_waiting", 32'(imem_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("rstmid_req_drop", 32'(imem_req), 32'd0);
      check_eq("rstmid_pc", 32'(imem_addr), 32'd0);
      check_eq("rstmid_ir", 32'(ir), 32'd0);
      imem_wait = 0;
      imem[0] = 16'h3640; imem[1] = 16'h3740; imem[2] = 16'hF000;
      push_wb(2'd1, 32'd0, -1); push_wb(2'd1, 32'd0, 4);
      fq.push_back(0); fq.push_back(2); fq.push_back(4);
      @(negedge clk);
      rst = 1'b0;
      run_until_halt("rstmid_halt", 300);
      end_test("rstmid");

      // 32-bit datapath
      wbq_w.push_back('{2'd1, 32'hFFFF_FFFF, -1});
      wbq_w.push_back('{2'd2, 32'd1, 4});
      @(negedge clk);
      rst32 = 1'b0;
      for (int i = 0; i < 200 && !halted_w; i++) @(negedge clk);
      check_eq("w32_halt", 32'(halted_w), 32'd1);
      check_eq("w32_wb_left", 32'(wbq_w.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Parametrised multi-cycle successor to the single-cycle 16-bit MIPS datapath. It executes the same 16-bit instruction encoding and adds working LW, SW, BEQ and HALT. Instruction and data memories sit outside the core and are reached through req/ack handshake ports, so either memory may insert wait states. The core is the CPU instance under the system testbench and presents a write-back trace port for checking.

## Interface
- DATA_W, 16: datapath and register width; must be ≥ 8.
- PC_W, 16: program counter and memory address width.
- PC_STEP, 2: byte increment per instruction; legal values are 1, 2 and 4.
- clock  in  1  system clock; rising-edge active.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address; equals the PC.
- imem_ack  in  1  fetch complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  16  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  PC_W  effective address, taken from the low PC_W bits of the ALU result.
- dmem_wdata  out  DATA_W  store data (rt).
- dmem_ack  in  1  data access complete; dmem_rdata is valid in the same cycle.
- dmem_rdata  in  DATA_W  load data.
- ir  out  16  current instruction register.
- wb_valid  out  1  one-cycle pulse when a register is written.
- wb_reg  out  2  destination register of the write.
- wb_data  out  DATA_W  value written.
- halted  out  1  core is stopped in HALT.

## Operation
- Instruction fields:
  - op = ir[15:12], rs = ir[11:10], rt = ir[9:8], rd = ir[7:6].
  - imm = ir[7:0], sign-extended to DATA_W.
- Opcodes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0111 slt: rd ← rs op rt.
  - 0100 addi: rt ← rs + imm.
  - 0101 lw: rt ← mem[rs + imm].
  - 0110 sw: mem[rs + imm] ← rt.
  - 1000 beq: if rs == rt, PC ← PC + imm·PC_STEP, where PC is the already-incremented value.
  - 1111 halt.
  - Any other opcode is a NOP: no register or memory write; the PC still advances.
- Register file: 4 × DATA_W. $0 always reads 0, and writes to $0 are discarded without a wb_valid pulse.
- Arithmetic:
  - add, sub and addi wrap modulo 2^DATA_W.
  - slt is a signed compare over the full DATA_W and produces 1 or 0.
  - The zero flag covers all DATA_W bits.
- FSM states and transitions:
  - FETCH: imem_req = 1 until imem_ack. On ack, latch ir and set PC ← PC + PC_STEP, then go to DECODE.
  - DECODE: latch A = reg[rs] and B = reg[rt]. HALT → HALT; otherwise → EXEC.
  - EXEC: latch ALUOut. beq resolves its branch here and returns to FETCH. lw and sw go to MEM. R-type and addi go to WB. NOP returns to FETCH.
  - MEM: dmem_req = 1 until dmem_ack. sw returns to FETCH. lw latches rdata and goes to WB.
  - WB: write the register, pulse wb_valid, then go to FETCH.
  - HALT: all requests low and halted = 1. Only reset leaves this state.
- Request behaviour: imem_req and dmem_req each hold steady, with stable address and data, until the matching ack is sampled. Ack is ignored while the corresponding req is low.

## Timing
- Cycle counts with zero-wait acks (ack in the first req cycle):
  - R-type, addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles (taken or not).
  - NOP: 3 cycles.
- Each cycle an ack is withheld adds one cycle in FETCH or MEM.
- The register write takes effect at the rising edge that ends WB. A following instruction that reads the register in DECODE sees the new value.
- Reset values:
  - PC = 0, state = FETCH, all registers = 0, ir = 0.
  - All outputs = 0, except imem_addr = 0.
- imem_req rises in the first cycle after reset deasserts.
- Reset asserted mid-transaction drops req immediately, since reset is asynchronous. No register write occurs, and an in-flight ack is ignored.

## Test plan
- Load the 8-instruction program (addi $1,$0,15; addi $2,$0,7; and $3,$1,$2; sub $2,$1,$3; or $2,$2,$3; add $3,$2,$3; slt $1,$3,$2; slt $1,$2,$3) with zero-wait memory. Expected wb trace: (1,15) (2,7) (3,7) (2,8) (2,15) (3,22) (1,0) (1,1), with 4-cycle spacing.
- Run sw $1 → addr 0x10, then lw $2 ← 0x10, with 3 wait cycles on dmem_ack. Expected: dmem_we = 1 then 0, addr 0x10 for both, wb (2, value of $1), and the lw takes 8 cycles.
- Place beq $1,$1 with imm = 0xFF at PC = 6 (PC_STEP = 2). Expected: next fetch address 6, giving a self-loop. With rs ≠ rt, the next fetch address is 8.
- Execute addi $0,$0,5, then opcode 1010, then halt. Expected: no wb_valid pulses; imem_addr advances 0, 2, 4; halted = 1 is held thereafter.
- Assert reset during a fetch wait, then deassert. Expected: imem_req drops the same cycle, the next fetch is at PC = 0, and all registers read 0.
- Elaborate with DATA_W = 32: addi $1,$0,-1 followed by slt $2,$1,$0. Expected: wb (1, 0xFFFFFFFF) then (2, 1).
